ul_reg_bank_mc: RTL and testbench

//  Parametrised, multi-channel user-logic register bank behind the MPI-style CPU port.

---
 rtl/ul_cpu_if.sv | 22 ++
 rtl/ul_reg_bank_mc.sv | 204 ++++++++++++++++++++
 tb/tb_ul_reg_bank_mc.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ul_cpu_if.sv
// CPU register-access port: shared rd/wr address, 1-cycle strobes, registered read data with valid.
interface ul_cpu_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [DATA_W-1:0] cpu_data_in;
    logic              cpu_rd;
    logic [DATA_W-1:0] cpu_data_out;
    logic              cpu_rd_vld;

    modport master (
        output cpu_wr, cpu_wr_addr, cpu_data_in, cpu_rd,
        input  cpu_data_out, cpu_rd_vld
    );

    modport slave (
        input  cpu_wr, cpu_wr_addr, cpu_data_in, cpu_rd,
        output cpu_data_out, cpu_rd_vld
    );
endinterface

// File: rtl/ul_reg_bank_mc.sv
// Multi-channel user-logic register bank: version/capability, LED/timeout config,
// W1C error status with mask/irq, per-channel pipelined adders and a read-access counter.
module ul_reg_bank_mc #(
    parameter int unsigned CPU_ADDR_WIDTH = 12,
    parameter int unsigned CPU_DATA_WIDTH = 32,
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned ERR_WIDTH      = 2,
    parameter logic [31:0] VER_TIME       = 32'h2018_0315,
    parameter logic [31:0] VER_TYPE       = 32'h00D2_0007,
    parameter logic [15:0] TMOUT_INIT     = 16'hFFFF
) (
    input  logic                        clks,
    input  logic                        reset,
    ul_cpu_if.slave                     cpu,
    output logic [15:0]                 ul2sh_vled,
    output logic [15:0]                 reg_tmout_us_cfg,
    input  logic [NUM_CH*ERR_WIDTH-1:0] err_in,
    output logic                        irq
);

    localparam int unsigned DW = CPU_DATA_WIDTH;
    localparam int unsigned EW = NUM_CH * ERR_WIDTH;

    localparam logic [11:0] A_VER_TIME = 12'h000;
    localparam logic [11:0] A_VER_TYPE = 12'h001;
    localparam logic [11:0] A_CAP      = 12'h002;
    localparam logic [11:0] A_TEST     = 12'h003;
    localparam logic [11:0] A_VLED     = 12'h004;
    localparam logic [11:0] A_TMOUT    = 12'h005;
    localparam logic [11:0] A_ERR_STS  = 12'h006;
    localparam logic [11:0] A_ERR_MASK = 12'h007;
    localparam logic [11:0] A_RD_CNT   = 12'h008;
    localparam logic [11:0] A_CH_BASE  = 12'h010;
    localparam logic [11:0] A_CH_END   = 12'(16 + 4 * NUM_CH);

    // Address decode: only addr[11:0] is significant, any upper bit set means unmapped
    logic [11:0] addr;
    logic        addr_ok;

    assign addr = 12'(cpu.cpu_wr_addr);

    generate
        if (CPU_ADDR_WIDTH > 12) begin : g_addr_hi
            assign addr_ok = ~|cpu.cpu_wr_addr[CPU_ADDR_WIDTH-1:12];
        end else begin : g_addr_lo
            assign addr_ok = 1'b1;
        end
    endgenerate

    logic        wr_en;
    logic        in_ch;
    logic [11:0] ch_off;
    logic [7:0]  ch_idx;
    logic [1:0]  ch_reg;

    assign wr_en  = cpu.cpu_wr & addr_ok;
    assign in_ch  = addr_ok && (addr >= A_CH_BASE) && (addr < A_CH_END);
    assign ch_off = addr - A_CH_BASE;
    assign ch_idx = 8'(ch_off >> 2);
    assign ch_reg = 2'(ch_off);

    // Register state
    logic [DW-1:0] test_q;
    logic [15:0]   vled_q;
    logic [15:0]   tmout_q;
    logic [EW-1:0] err_sts_q;
    logic [EW-1:0] err_mask_q;
    logic [DW-1:0] rd_cnt_q;
    logic          irq_q;
    logic [DW-1:0] data_out_q;
    logic          rd_vld_q;

    logic [DW-1:0]     opa_q [NUM_CH];
    logic [DW-1:0]     opb_q [NUM_CH];
    logic [DW:0]       s1_q  [NUM_CH];
    logic [DW-1:0]     sum_q [NUM_CH];
    logic [NUM_CH-1:0] upd_q;
    logic [NUM_CH-1:0] s1_vld_q;
    logic [NUM_CH-1:0] carry_q;

    // Per-channel write strobes
    logic [NUM_CH-1:0] wr_opa_c;
    logic [NUM_CH-1:0] wr_opb_c;
    logic [NUM_CH-1:0] clr_carry_c;

    always_comb begin
        wr_opa_c    = '0;
        wr_opb_c    = '0;
        clr_carry_c = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en && in_ch && (ch_idx == 8'(c))) begin
                case (ch_reg)
                    2'd0:    wr_opa_c[c]    = 1'b1;
                    2'd1:    wr_opb_c[c]    = 1'b1;
                    2'd3:    clr_carry_c[c] = cpu.cpu_data_in[0];
                    default: ;
                endcase
            end
        end
    end

    logic [EW-1:0] err_w1c_c;
    assign err_w1c_c = (wr_en && (addr == A_ERR_STS)) ? cpu.cpu_data_in[EW-1:0] : '0;

    // Read mux sees pre-write register values, so a same-cycle rd/wr returns the old value
    logic [DW-1:0] rd_data_c;

    always_comb begin
        rd_data_c = '0;
        if (addr_ok) begin
            if (in_ch) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ch_idx == 8'(c)) begin
                        case (ch_reg)
                            2'd0:    rd_data_c = opa_q[c];
                            2'd1:    rd_data_c = opb_q[c];
                            2'd2:    rd_data_c = sum_q[c];
                            default: rd_data_c = DW'(carry_q[c]);
                        endcase
                    end
                end
            end else begin
                case (addr)
                    A_VER_TIME: rd_data_c = DW'(VER_TIME);
                    A_VER_TYPE: rd_data_c = DW'(VER_TYPE);
                    A_CAP:      rd_data_c = DW'({8'(ERR_WIDTH), 8'(NUM_CH)});
                    A_TEST:     rd_data_c = ~test_q;
                    A_VLED:     rd_data_c = DW'(vled_q);
                    A_TMOUT:    rd_data_c = DW'(tmout_q);
                    A_ERR_STS:  rd_data_c = DW'(err_sts_q);
                    A_ERR_MASK: rd_data_c = DW'(err_mask_q);
                    A_RD_CNT:   rd_data_c = rd_cnt_q;
                    default:    rd_data_c = '0;
                endcase
            end
        end
    end

    // Config, status, read port and access counter
    always_ff @(posedge clks or posedge reset) begin
        if (reset) begin
            test_q     <= '0;
            vled_q     <= '0;
            tmout_q    <= TMOUT_INIT;
            err_sts_q  <= '0;
            err_mask_q <= '1;
            rd_cnt_q   <= '0;
            irq_q      <= 1'b0;
            data_out_q <= '0;
            rd_vld_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                case (addr)
                    A_TEST:     test_q     <= cpu.cpu_data_in;
                    A_VLED:     vled_q     <= cpu.cpu_data_in[15:0];
                    A_TMOUT:    tmout_q    <= cpu.cpu_data_in[15:0];
                    A_ERR_MASK: err_mask_q <= cpu.cpu_data_in[EW-1:0];
                    default:    ;
                endcase
            end
            err_sts_q <= (err_sts_q & ~err_w1c_c) | err_in;
            irq_q     <= |(err_sts_q & ~err_mask_q);
            rd_vld_q  <= cpu.cpu_rd;
            if (cpu.cpu_rd) begin
                data_out_q <= rd_data_c;
                if (addr_ok && (addr == A_RD_CNT)) begin
                    rd_cnt_q <= rd_cnt_q + DW'(1);
                end
            end
        end
    end

    // Adder channels: operands -> s1 (W+1 bits) -> SUM; carry only latches on a fresh result
    always_ff @(posedge clks or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                opa_q[c] <= '0;
                opb_q[c] <= '0;
                s1_q[c]  <= '0;
                sum_q[c] <= '0;
            end
            upd_q    <= '0;
            s1_vld_q <= '0;
            carry_q  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_opa_c[c]) opa_q[c] <= cpu.cpu_data_in;
                if (wr_opb_c[c]) opb_q[c] <= cpu.cpu_data_in;
                s1_q[c]  <= {1'b0, opa_q[c]} + {1'b0, opb_q[c]};
                sum_q[c] <= s1_q[c][DW-1:0];
                carry_q[c] <= (carry_q[c] & ~clr_carry_c[c]) | (s1_vld_q[c] & s1_q[c][DW]);
            end
            upd_q    <= wr_opa_c | wr_opb_c;
            s1_vld_q <= upd_q;
        end
    end

    assign cpu.cpu_data_out = data_out_q;
    assign cpu.cpu_rd_vld   = rd_vld_q;
    assign ul2sh_vled       = vled_q;
    assign reg_tmout_us_cfg = tmout_q;
    assign irq              = irq_q;

endmodule

// File: tb/tb_ul_reg_bank_mc.sv
// Directed bench for ul_reg_bank_mc: hand-computed register values checked with immediate assertions.
module tb_ul_reg_bank_mc;

    logic       clks;
    logic       reset;
    logic [7:0] err_in;
    logic [15:0] ul2sh_vled;
    logic [15:0] reg_tmout_us_cfg;
    logic        irq;

    int unsigned total;
    int unsigned bad;

    ul_cpu_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    ul_reg_bank_mc dut (
        .clks             (clks),
        .reset            (reset),
        .cpu              (bus),
        .ul2sh_vled       (ul2sh_vled),
        .reg_tmout_us_cfg (reg_tmout_us_cfg),
        .err_in           (err_in),
        .irq              (irq)
    );

    initial clks = 1'b0;
    always #5 clks = ~clks;

    task automatic cyc();
        @(posedge clks);
        @(negedge clks);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.cpu_wr      = 1'b1;
        bus.cpu_wr_addr = a;
        bus.cpu_data_in = d;
        cyc();
        bus.cpu_wr      = 1'b0;
        bus.cpu_data_in = '0;
    endtask

    // Read with data check, valid exactly one cycle after the strobe, data held afterwards
    task automatic rd_chk(input logic [11:0] a, input logic [31:0] exp, input string tag);
        bus.cpu_rd      = 1'b1;
        bus.cpu_wr_addr = a;
        cyc();
        bus.cpu_rd = 1'b0;
        chk({tag, " data"}, bus.cpu_data_out, exp);
        chk({tag, " vld"}, 32'(bus.cpu_rd_vld), 32'h1);
        cyc();
        chk({tag, " vld_pulse"}, 32'(bus.cpu_rd_vld), 32'h0);
        chk({tag, " hold"}, bus.cpu_data_out, exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        err_in = '0;
        bus.cpu_wr      = 1'b0;
        bus.cpu_rd      = 1'b0;
        bus.cpu_wr_addr = '0;
        bus.cpu_data_in = '0;
        cyc();
        cyc();
        chk("rst data_out", bus.cpu_data_out, 32'h0);
        chk("rst rd_vld", 32'(bus.cpu_rd_vld), 32'h0);
        chk("rst vled", 32'(ul2sh_vled), 32'h0);
        chk("rst tmout", 32'(reg_tmout_us_cfg), 32'h0000_FFFF);
        chk("rst irq", 32'(irq), 32'h0);
        reset = 1'b0;
        cyc();

        // 1. identity and reset values
        rd_chk(12'h000, 32'h2018_0315, "ver_time");
        rd_chk(12'h001, 32'h00D2_0007, "ver_type");
        rd_chk(12'h002, 32'h0000_0204, "cap");
        rd_chk(12'h005, 32'h0000_FFFF, "tmout_rst");
        rd_chk(12'h007, 32'h0000_00FF, "mask_rst");

        // 2. ch2 adder: old sum until N+3, then new sum and carry
        wr(12'h018, 32'hFFFF_FFFF);
        wr(12'h019, 32'h0000_0002);
        cyc();
        bus.cpu_rd      = 1'b1;
        bus.cpu_wr_addr = 12'h01A;
        cyc();
        chk("sum_early", bus.cpu_data_out, 32'hFFFF_FFFF);
        cyc();
        bus.cpu_rd = 1'b0;
        chk("sum_n3", bus.cpu_data_out, 32'h0000_0001);
        chk("sum_n3 vld", 32'(bus.cpu_rd_vld), 32'h1);
        cyc();
        rd_chk(12'h01B, 32'h0000_0001, "carry_set");
        rd_chk(12'h018, 32'hFFFF_FFFF, "opa_rb");
        rd_chk(12'h019, 32'h0000_0002, "opb_rb");
        wr(12'h01B, 32'h0000_0001);
        rd_chk(12'h01B, 32'h0000_0000, "carry_clr");
        rd_chk(12'h012, 32'h0000_0000, "ch0_sum_idle");

        // 3. error status, mask and irq
        err_in = 8'h08;
        cyc();
        err_in = 8'h00;
        rd_chk(12'h006, 32'h0000_0008, "err_sts_set");
        chk("irq_masked", 32'(irq), 32'h0);
        wr(12'h007, 32'h0000_0000);
        chk("irq_pre", 32'(irq), 32'h0);
        cyc();
        chk("irq_unmask", 32'(irq), 32'h1);
        bus.cpu_wr      = 1'b1;
        bus.cpu_wr_addr = 12'h006;
        bus.cpu_data_in = 32'h0000_0008;
        err_in          = 8'h08;
        cyc();
        bus.cpu_wr = 1'b0;
        err_in     = 8'h00;
        rd_chk(12'h006, 32'h0000_0008, "err_set_wins");
        chk("irq_held", 32'(irq), 32'h1);
        wr(12'h006, 32'h0000_0008);
        cyc();
        chk("irq_clr", 32'(irq), 32'h0);
        rd_chk(12'h006, 32'h0000_0000, "err_w1c");
        wr(12'h007, 32'hFFFF_FFFF);
        rd_chk(12'h007, 32'h0000_00FF, "mask_width");

        // 4. read counter and wrap
        rd_chk(12'h008, 32'h0000_0000, "rdcnt0");
        rd_chk(12'h008, 32'h0000_0001, "rdcnt1");
        rd_chk(12'h008, 32'h0000_0002, "rdcnt2");
        force dut.rd_cnt_q = 32'hFFFF_FFFF;
        cyc();
        release dut.rd_cnt_q;
        cyc();
        rd_chk(12'h008, 32'hFFFF_FFFF, "rdcnt_max");
        rd_chk(12'h008, 32'h0000_0000, "rdcnt_wrap");

        // 5. test register, RO write, unmapped, same-cycle rd/wr
        rd_chk(12'h003, 32'hFFFF_FFFF, "test_rst");
        wr(12'h003, 32'h1234_5678);
        rd_chk(12'h003, 32'hEDCB_A987, "test_inv");
        wr(12'h000, 32'h0000_0000);
        rd_chk(12'h000, 32'h2018_0315, "ro_write");
        rd_chk(12'h020, 32'h0000_0000, "ch4_unmapped");
        rd_chk(12'h0FF, 32'h0000_0000, "unmapped_ff");
        wr(12'h004, 32'hFFFF_1234);
        rd_chk(12'h004, 32'h0000_1234, "vled_rb");
        chk("vled_port", 32'(ul2sh_vled), 32'h0000_1234);
        bus.cpu_wr      = 1'b1;
        bus.cpu_rd      = 1'b1;
        bus.cpu_wr_addr = 12'h005;
        bus.cpu_data_in = 32'h0000_0ABC;
        cyc();
        bus.cpu_wr = 1'b0;
        bus.cpu_rd = 1'b0;
        chk("rdwr_old", bus.cpu_data_out, 32'h0000_FFFF);
        cyc();
        rd_chk(12'h005, 32'h0000_0ABC, "tmout_new");
        chk("tmout_port", 32'(reg_tmout_us_cfg), 32'h0000_0ABC);

        // 6. reset between operand write and sum read, with a read in flight
        wr(12'h004, 32'h0000_00AA);
        wr(12'h010, 32'hFFFF_FFFF);
        wr(12'h011, 32'h0000_0001);
        bus.cpu_rd      = 1'b1;
        bus.cpu_wr_addr = 12'h012;
        #2 reset = 1'b1;
        @(negedge clks);
        chk("rst_mid vld", 32'(bus.cpu_rd_vld), 32'h0);
        chk("rst_mid data", bus.cpu_data_out, 32'h0);
        chk("rst_mid vled", 32'(ul2sh_vled), 32'h0);
        bus.cpu_rd = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        cyc();
        rd_chk(12'h012, 32'h0000_0000, "rst_sum");
        rd_chk(12'h013, 32'h0000_0000, "rst_carry");
        rd_chk(12'h005, 32'h0000_FFFF, "rst_tmout");
        rd_chk(12'h008, 32'h0000_0000, "rst_rdcnt");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
